minibyte_bus_arbiter: RTL and testbench
=======================================

// Module: minibyte_bus_arbiter
// PURPOSE
//   Shares the single 8-bit memory port between the instruction-fetch requester and the
//   load/store (data) requester. Sequences one access at a time with round-robin priority.
//   Drives the select of the external 8-bit 2:1 address mux (minibyte_genmux):
//   a_in = fetch address, b_in = data address.
//   Also generates memory enable/write strobes and captures read data for the winner.
// PARAMETERS
//   WAIT_CYCLES  1   memory access cycles per transaction; legal 1..15; elaboration error outside
// PORTS
//   clk             in   1  system clock, all state on rising edge
//   rst_n           in   1  asynchronous active-low reset
//   fetch_req_in    in   1  fetch requester wants an access (always a read)
//   data_req_in     in   1  data requester wants an access
//   data_we_in      in   1  data access is a write (sampled at grant)
//   mem_rdata_in    in   8  read data from memory
//   fetch_gnt_out   out  1  fetch owns the memory port (ACCESS with owner=fetch)
//   data_gnt_out    out  1  data owns the memory port (ACCESS with owner=data)
//   fetch_done_out  out  1  one-cycle pulse: fetch transaction complete, rdata_out valid
//   data_done_out   out  1  one-cycle pulse: data transaction complete (rdata_out valid if read)
//   mux_sel_out     out  1  address mux select; 0=fetch address, 1=data address
//   mem_en_out      out  1  memory enable, high for every ACCESS cycle
//   mem_we_out      out  1  memory write strobe, high in ACCESS cycles of a data write
//   rdata_out       out  8  captured read data, held until the next read completes
//   busy_out        out  1  high whenever state != IDLE
// BEHAVIOUR
//   Reset values (async, immediate): state=IDLE, all outputs 0, rdata_out=8'h00,
//     counter=0, last_owner=data (fetch wins the first tie).
//   States: IDLE -> ACCESS -> DONE -> IDLE.
//     One transaction per WAIT_CYCLES+2 cycles max.
//   IDLE: requests sampled only here.
//     - Neither request: stay in IDLE.
//     - One request: grant it.
//     - Both requests: grant the requester that is not last_owner.
//     - On grant: latch owner and we (we forced 0 for fetch).
//     - On grant: counter = WAIT_CYCLES-1, update last_owner, go to ACCESS.
//   ACCESS: lasts exactly WAIT_CYCLES cycles.
//     - mux_sel_out = owner, mem_en_out = 1, mem_we_out = latched we.
//     - Owner's gnt_out = 1; counter decrements each cycle.
//     - In the cycle counter==0: if a read, rdata_out <= mem_rdata_in at that edge; go to DONE.
//   DONE: one cycle.
//     - Owner's done_out = 1; gnt, mem_en and mem_we are 0.
//     - mux_sel_out holds the owner value. Go to IDLE.
//   IDLE outputs: mux_sel_out holds the last owner value. gnt, done, en and we are 0.
//   Timing: request seen in IDLE at cycle N -> gnt high N+1..N+WAIT_CYCLES.
//     done pulse at N+WAIT_CYCLES+1. Earliest next grant is N+WAIT_CYCLES+3.
//   Requesters hold address and write data stable from request until their done pulse.
//   Dropping a request during ACCESS does not abort: the access completes and done still pulses.
//   A request held after done is treated as a new request (back-to-back is allowed).
//     Round-robin applies if the other requester is also waiting.
//   Writes never update rdata_out. Both gnt outputs are never high together.
//     Both done outputs are never high together.
//   Reset mid-transaction: immediate return to IDLE, strobes drop asynchronously.
//     No done pulse; the aborted access is not retried.
// TESTING
//   1 Reset, then fetch_req only, WAIT_CYCLES=1, mem_rdata=8'hA5.
//     -> fetch_gnt 1 cycle, mux_sel=0, fetch_done next cycle, rdata_out=8'hA5.
//   2 Both reqs held high continuously.
//     -> grants alternate fetch, data, fetch, data; mux_sel tracks owner; never both gnt.
//   3 Data write, data_we=1, WAIT_CYCLES=3.
//     -> mem_en and mem_we high exactly 3 cycles, mux_sel=1, data_done 1 cycle.
//     -> rdata_out unchanged from prior read (8'hA5).
//   4 fetch_req dropped in 2nd ACCESS cycle (WAIT_CYCLES=3).
//     -> access runs all 3 cycles, fetch_done pulses, then IDLE with busy_out=0.
//   5 rst_n low in 2nd ACCESS cycle.
//     -> mem_en, mem_we, gnt = 0 immediately; no done; after release fetch wins the first tie.
//   6 Scoreboard over 1000 random req/we cycles.
//     -> every granted access yields exactly one done; latency = WAIT_CYCLES+1 from grant.

Source files
------------

// File: rtl/minibyte_bus_arbiter.sv
// Round-robin arbiter sharing one 8-bit memory port between instruction fetch and data access.
// Sequences IDLE -> ACCESS (WAIT_CYCLES cycles) -> DONE, drives mux select and memory strobes.
module minibyte_bus_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fetch_req_in,
  input  logic       data_req_in,
  input  logic       data_we_in,
  input  logic [7:0] mem_rdata_in,
  output logic       fetch_gnt_out,
  output logic       data_gnt_out,
  output logic       fetch_done_out,
  output logic       data_done_out,
  output logic       mux_sel_out,
  output logic       mem_en_out,
  output logic       mem_we_out,
  output logic [7:0] rdata_out,
  output logic       busy_out
);

  if (WAIT_CYCLES == 0 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
    $error("minibyte_bus_arbiter: WAIT_CYCLES must be in 1..15");
  end

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;

  localparam logic [3:0] CntInit = 4'(WAIT_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic       owner_q, owner_d;   // 0 = fetch, 1 = data
  logic       we_q, we_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_q, last_d;     // previous winner, 0 = fetch, 1 = data
  logic [7:0] rdata_q, rdata_d;
  logic       win_data;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    rdata_d  = rdata_q;
    // On a tie the requester that did not win last time gets the port.
    win_data = data_req_in && (!fetch_req_in || !last_q);

    case (state_q)
      StIdle: begin
        if (fetch_req_in || data_req_in) begin
          owner_d = win_data;
          we_d    = win_data && data_we_in;
          cnt_d   = CntInit;
          last_d  = win_data;
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            rdata_d = mem_rdata_in;
          end
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= 4'd0;
      last_q  <= 1'b1;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decode straight from state so reset drops every strobe asynchronously.
  assign fetch_gnt_out  = (state_q == StAccess) && !owner_q;
  assign data_gnt_out   = (state_q == StAccess) &&  owner_q;
  assign fetch_done_out = (state_q == StDone)   && !owner_q;
  assign data_done_out  = (state_q == StDone)   &&  owner_q;
  assign mux_sel_out    = owner_q;
  assign mem_en_out     = (state_q == StAccess);
  assign mem_we_out     = (state_q == StAccess) && we_q;
  assign rdata_out      = rdata_q;
  assign busy_out       = (state_q != StIdle);

endmodule

// File: tb/tb_minibyte_bus_arbiter.sv
// Self-checking bench for minibyte_bus_arbiter: vector table, directed corner cases and a
// transaction-window reference model driven by random requests, on WAIT_CYCLES=1 and 3.
module tb_minibyte_bus_arbiter;

  // Flag order: fg dg fd dd mux en we busy, then rdata.
  typedef struct packed {
    logic       fg;
    logic       dg;
    logic       fd;
    logic       dd;
    logic       mux;
    logic       en;
    logic       we;
    logic       busy;
    logic [7:0] rdata;
  } outs_t;

  typedef struct {
    logic       f;
    logic       d;
    logic       we;
    logic [7:0] rd;
    outs_t      exp;
  } vec_t;

  logic            clk;
  logic [1:0]      rst_n;
  logic [1:0]      fetch_req;
  logic [1:0]      data_req;
  logic [1:0]      data_we;
  logic [1:0][7:0] mem_rdata;
  logic [1:0][7:0] rdata;
  logic [1:0]      fg, dg, fd, dd, mux, en, we, busy;

  int total = 0;
  int bad   = 0;
  int wcyc[2] = '{1, 3};

  // Reference model: one transaction window per instance, in absolute cycle numbers.
  int         m_start[2];
  int         m_end[2];
  int         m_free[2];
  logic       m_owner[2];
  logic       m_we[2];
  logic       m_last[2];
  logic [7:0] m_rdata[2];

  vec_t vecs[$];

  minibyte_bus_arbiter #(.WAIT_CYCLES(1)) u_dut_w1 (
    .clk           (clk),
    .rst_n         (rst_n[0]),
    .fetch_req_in  (fetch_req[0]),
    .data_req_in   (data_req[0]),
    .data_we_in    (data_we[0]),
    .mem_rdata_in  (mem_rdata[0]),
    .fetch_gnt_out (fg[0]),
    .data_gnt_out  (dg[0]),
    .fetch_done_out(fd[0]),
    .data_done_out (dd[0]),
    .mux_sel_out   (mux[0]),
    .mem_en_out    (en[0]),
    .mem_we_out    (we[0]),
    .rdata_out     (rdata[0]),
    .busy_out      (busy[0])
  );

  minibyte_bus_arbiter #(.WAIT_CYCLES(3)) u_dut_w3 (
    .clk           (clk),
    .rst_n         (rst_n[1]),
    .fetch_req_in  (fetch_req[1]),
    .data_req_in   (data_req[1]),
    .data_we_in    (data_we[1]),
    .mem_rdata_in  (mem_rdata[1]),
    .fetch_gnt_out (fg[1]),
    .data_gnt_out  (dg[1]),
    .fetch_done_out(fd[1]),
    .data_done_out (dd[1]),
    .mux_sel_out   (mux[1]),
    .mem_en_out    (en[1]),
    .mem_we_out    (we[1]),
    .rdata_out     (rdata[1]),
    .busy_out      (busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t get_outs(input int k);
    return {fg[k], dg[k], fd[k], dd[k], mux[k], en[k], we[k], busy[k], rdata[k]};
  endfunction

  function automatic string fmt(input outs_t o);
    return $sformatf("fg=%b dg=%b fd=%b dd=%b mux=%b en=%b we=%b busy=%b rdata=%h",
                     o.fg, o.dg, o.fd, o.dd, o.mux, o.en, o.we, o.busy, o.rdata);
  endfunction

  task automatic check_outs(input string nm, input outs_t act, input outs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %s, expected %s", nm, fmt(act), fmt(exp));
    end
  endtask

  task automatic check_val(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic f, input logic d, input logic w, input logic [7:0] rd,
                         input logic [7:0] flags, input logic [7:0] rd_exp);
    vec_t v;
    v.f   = f;
    v.d   = d;
    v.we  = w;
    v.rd  = rd;
    v.exp = outs_t'({flags, rd_exp});
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    rst_n     = 2'b00;
    fetch_req = 2'b00;
    data_req  = 2'b00;
    data_we   = 2'b00;
    mem_rdata = '0;
    tick();
    for (int k = 0; k < 2; k++) begin
      check_outs($sformatf("reset state k%0d", k), get_outs(k), '0);
    end
    @(negedge clk);
    rst_n = 2'b11;
    tick();
  endtask

  task automatic model_init(input int k);
    m_start[k] = -10;
    m_end[k]   = -10;
    m_free[k]  = 0;
    m_owner[k] = 1'b0;
    m_we[k]    = 1'b0;
    m_last[k]  = 1'b1;
    m_rdata[k] = 8'h00;
  endtask

  // Expected outputs for cycle t depend only on where t falls in the current window.
  task automatic check_model(input int k, input int t);
    outs_t e;
    logic  acc;
    logic  dn;
    acc     = (t >= m_start[k]) && (t <= m_end[k]);
    dn      = (t == m_end[k] + 1);
    e.fg    = acc && !m_owner[k];
    e.dg    = acc && m_owner[k];
    e.fd    = dn && !m_owner[k];
    e.dd    = dn && m_owner[k];
    e.mux   = m_owner[k];
    e.en    = acc;
    e.we    = acc && m_we[k];
    e.busy  = acc || dn;
    e.rdata = m_rdata[k];
    check_outs($sformatf("rand k%0d t%0d", k, t), get_outs(k), e);
  endtask

  // Called with the inputs presented during cycle t.
  task automatic model_step(input int k, input int t);
    logic win;
    if (t == m_end[k] && !m_we[k]) m_rdata[k] = mem_rdata[k];
    if (t >= m_free[k] && (fetch_req[k] || data_req[k])) begin
      if (fetch_req[k] && data_req[k]) win = !m_last[k];
      else                             win = data_req[k];
      m_owner[k] = win;
      m_we[k]    = win && data_we[k];
      m_last[k]  = win;
      m_start[k] = t + 1;
      m_end[k]   = t + wcyc[k];
      m_free[k]  = t + wcyc[k] + 2;
    end
  endtask

  int n_en, n_we, n_g, n_mux, n_dd, n_fd;

  initial begin
    // Vectors for the WAIT_CYCLES=1 instance; each row shows outputs after its clock edge.
    //        f  d  we rd     flags         rdata
    add_vec(1, 0, 0, 8'hA5, 8'b1000_0101, 8'h00);
    add_vec(0, 0, 0, 8'hA5, 8'b0010_0001, 8'hA5);
    add_vec(0, 0, 0, 8'h00, 8'b0000_0000, 8'hA5);
    add_vec(1, 1, 0, 8'h3C, 8'b0100_1101, 8'hA5);  // last owner fetch, so data wins
    add_vec(1, 1, 0, 8'h3C, 8'b0001_1001, 8'h3C);
    add_vec(1, 1, 0, 8'h00, 8'b0000_1000, 8'h3C);
    add_vec(1, 1, 0, 8'h00, 8'b1000_0101, 8'h3C);
    add_vec(1, 1, 0, 8'h5A, 8'b0010_0001, 8'h5A);
    add_vec(1, 1, 1, 8'h00, 8'b0000_0000, 8'h5A);
    add_vec(1, 1, 1, 8'hEE, 8'b0100_1111, 8'h5A);
    add_vec(0, 0, 0, 8'hEE, 8'b0001_1001, 8'h5A);  // write leaves rdata alone
    add_vec(0, 0, 0, 8'h00, 8'b0000_1000, 8'h5A);

    do_reset();

    for (int i = 0; i < vecs.size(); i++) begin
      fetch_req[0] = vecs[i].f;
      data_req[0]  = vecs[i].d;
      data_we[0]   = vecs[i].we;
      mem_rdata[0] = vecs[i].rd;
      tick();
      check_outs($sformatf("vec%0d", i), get_outs(0), vecs[i].exp);
    end

    // Data write on WAIT_CYCLES=3 after a read of 8'hA5.
    fetch_req[1] = 1'b1;
    mem_rdata[1] = 8'hA5;
    tick();
    fetch_req[1] = 1'b0;
    repeat (5) tick();
    check_val("w3 prior read rdata", rdata[1], 8'hA5);
    data_req[1]  = 1'b1;
    data_we[1]   = 1'b1;
    mem_rdata[1] = 8'h11;
    tick();
    data_req[1] = 1'b0;
    n_en = 0; n_we = 0; n_g = 0; n_mux = 0; n_dd = 0; n_fd = 0;
    for (int i = 0; i < 8; i++) begin
      if (en[1]) n_en++;
      if (we[1]) n_we++;
      if (dg[1]) n_g++;
      if (en[1] && !mux[1]) n_mux++;
      if (dd[1]) n_dd++;
      if (fd[1]) n_fd++;
      tick();
    end
    check_val("w3 write en cycles", n_en, 3);
    check_val("w3 write we cycles", n_we, 3);
    check_val("w3 write gnt cycles", n_g, 3);
    check_val("w3 write mux not data", n_mux, 0);
    check_val("w3 write data_done pulses", n_dd, 1);
    check_val("w3 write fetch_done pulses", n_fd, 0);
    check_val("w3 write keeps rdata", rdata[1], 8'hA5);
    data_we[1] = 1'b0;

    // Fetch request dropped in the second access cycle still completes.
    fetch_req[1] = 1'b1;
    mem_rdata[1] = 8'hC3;
    tick();
    n_g = 0; n_fd = 0;
    for (int i = 0; i < 8; i++) begin
      if (fg[1]) begin
        n_g++;
        if (n_g == 2) fetch_req[1] = 1'b0;
      end
      if (fd[1]) n_fd++;
      tick();
    end
    check_val("drop gnt cycles", n_g, 3);
    check_val("drop fetch_done pulses", n_fd, 1);
    check_val("drop busy after", busy[1], 0);
    check_val("drop rdata", rdata[1], 8'hC3);

    // Reset asserted in the second access cycle of a data write.
    data_req[1] = 1'b1;
    data_we[1]  = 1'b1;
    tick();
    tick();
    check_val("rst mid en before", en[1], 1);
    #2 rst_n[1] = 1'b0;
    #1;
    check_val("rst mid en", en[1], 0);
    check_val("rst mid we", we[1], 0);
    check_val("rst mid gnt", dg[1], 0);
    check_val("rst mid busy", busy[1], 0);
    fetch_req[1] = 1'b1;
    n_dd = 0;
    repeat (2) begin
      tick();
      n_dd += int'(dd[1]);
    end
    @(negedge clk);
    rst_n[1] = 1'b1;
    tick();
    n_dd += int'(dd[1]);
    check_val("rst no done", n_dd, 0);
    check_val("rst tie fetch gnt", fg[1], 1);
    check_val("rst tie data gnt", dg[1], 0);
    check_val("rst tie mux", mux[1], 0);
    fetch_req[1] = 1'b0;
    data_req[1]  = 1'b0;
    data_we[1]   = 1'b0;
    repeat (12) tick();

    // Random traffic on both instances against the window model.
    do_reset();
    for (int k = 0; k < 2; k++) model_init(k);
    for (int t = 0; t < 1000; t++) begin
      for (int k = 0; k < 2; k++) check_model(k, t);
      for (int k = 0; k < 2; k++) begin
        fetch_req[k] = ($urandom_range(99) < 55);
        data_req[k]  = ($urandom_range(99) < 50);
        data_we[k]   = $urandom_range(1) != 0;
        mem_rdata[k] = 8'($urandom);
      end
      for (int k = 0; k < 2; k++) model_step(k, t);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
